// File: rtl/mda_pkg.sv
// rtl/mda_pkg.sv - shared constants and types for the MDA text buffer
package mda_pkg;

    localparam int MDA_COLS   = 80;
    localparam int MDA_ROWS   = 25;
    localparam int MDA_CELL_W = 9;
    localparam int MDA_CELL_H = 14;
    localparam int VRAM_DEPTH = MDA_COLS * MDA_ROWS;

    typedef struct packed {
        logic [7:0] attr;
        logic [7:0] ch;
    } vram_word_t;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

endpackage

// File: rtl/mda_vram.sv
// rtl/mda_vram.sv - single-port text buffer RAM, registered read, write-first
module mda_vram #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2000
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata;

    // Callers only assert i_we for in-range addresses.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
            r_rdata       <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mda_vram_arbiter.sv
// rtl/mda_vram_arbiter.sv - shares the MDA text buffer between display, host and clear engine
module mda_vram_arbiter
    import mda_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int DEPTH  = VRAM_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_disp_req,
    input  logic [ADDR_W-1:0] i_disp_addr,
    output logic              o_disp_valid,
    output logic [DATA_W-1:0] o_disp_data,
    input  logic              i_host_valid,
    output logic              o_host_ready,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_rvalid,
    output logic [DATA_W-1:0] o_host_rdata,
    input  logic              i_clr_start,
    input  logic [DATA_W-1:0] i_clr_word,
    output logic              o_clr_busy
);

    clr_state_t        r_clr_state, w_clr_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr, w_clr_addr_nxt;
    vram_word_t        r_clr_word, w_clr_word_nxt;
    logic              w_clr_wr;

    logic              w_host_ready;
    logic              w_host_acc;

    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;
    logic              w_ram_we;
    logic              w_in_range;
    logic              w_rd_disp;
    logic              w_rd_host;

    logic              r_p1_disp;
    logic              r_p1_host;
    logic              r_p1_oor;
    logic              r_disp_valid;
    logic [DATA_W-1:0] r_disp_data;
    logic              r_host_rvalid;
    logic [DATA_W-1:0] r_host_rdata;

    assign w_host_ready = !i_reset && !i_disp_req && (r_clr_state == CLR_IDLE);
    assign w_host_acc   = i_host_valid && w_host_ready;
    assign w_clr_wr     = (r_clr_state == CLR_RUN) && !i_disp_req;

    // One RAM access per cycle: display, then host, then clear.
    always_comb begin
        w_ram_addr  = i_disp_addr;
        w_ram_wdata = r_clr_word;
        w_ram_we    = 1'b0;
        w_rd_disp   = 1'b0;
        w_rd_host   = 1'b0;
        if (!i_reset) begin
            if (i_disp_req) begin
                w_rd_disp = 1'b1;
            end else if (w_host_acc) begin
                w_ram_addr  = i_host_addr;
                w_ram_wdata = i_host_wdata;
                w_ram_we    = i_host_we;
                w_rd_host   = !i_host_we;
            end else if (w_clr_wr) begin
                w_ram_addr = r_clr_addr;
                w_ram_we   = 1'b1;
            end
        end
    end

    assign w_in_range = (w_ram_addr < ADDR_W'(DEPTH));

    mda_vram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_vram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we && w_in_range),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_clr_state_nxt = r_clr_state;
        w_clr_addr_nxt  = r_clr_addr;
        w_clr_word_nxt  = r_clr_word;
        case (r_clr_state)
            CLR_IDLE: begin
                if (i_clr_start) begin
                    w_clr_state_nxt = CLR_RUN;
                    w_clr_addr_nxt  = '0;
                    w_clr_word_nxt  = vram_word_t'(i_clr_word);
                end
            end
            CLR_RUN: begin
                // The counter only moves on cycles the display leaves free.
                if (w_clr_wr) begin
                    if (r_clr_addr == ADDR_W'(DEPTH - 1)) begin
                        w_clr_state_nxt = CLR_IDLE;
                        w_clr_addr_nxt  = '0;
                    end else begin
                        w_clr_addr_nxt = r_clr_addr + 1'b1;
                    end
                end
            end
            default: begin
                w_clr_state_nxt = CLR_IDLE;
                w_clr_addr_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clr_state <= CLR_IDLE;
            r_clr_addr  <= '0;
            r_clr_word  <= '0;
        end else begin
            r_clr_state <= w_clr_state_nxt;
            r_clr_addr  <= w_clr_addr_nxt;
            r_clr_word  <= w_clr_word_nxt;
        end
    end

    // Stage 1 tags travel alongside the RAM read; stage 2 is the output register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_p1_disp     <= 1'b0;
            r_p1_host     <= 1'b0;
            r_p1_oor      <= 1'b0;
            r_disp_valid  <= 1'b0;
            r_disp_data   <= '0;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
        end else begin
            r_p1_disp     <= w_rd_disp;
            r_p1_host     <= w_rd_host;
            r_p1_oor      <= !w_in_range;
            r_disp_valid  <= r_p1_disp;
            r_host_rvalid <= r_p1_host;
            if (r_p1_disp) begin
                r_disp_data <= r_p1_oor ? '0 : w_ram_rdata;
            end
            if (r_p1_host) begin
                r_host_rdata <= r_p1_oor ? '0 : w_ram_rdata;
            end
        end
    end

    assign o_host_ready  = w_host_ready;
    assign o_disp_valid  = r_disp_valid;
    assign o_disp_data   = r_disp_data;
    assign o_host_rvalid = r_host_rvalid;
    assign o_host_rdata  = r_host_rdata;
    assign o_clr_busy    = (r_clr_state == CLR_RUN);

endmodule

// File: tb/tb_mda_vram_arbiter.sv
// tb/tb_mda_vram_arbiter.sv - self-checking bench for mda_vram_arbiter
module tb_mda_vram_arbiter;

    logic        clk;
    logic        i_reset;
    logic        i_disp_req;
    logic [10:0] i_disp_addr;
    logic        o_disp_valid;
    logic [15:0] o_disp_data;
    logic        i_host_valid;
    logic        o_host_ready;
    logic        i_host_we;
    logic [10:0] i_host_addr;
    logic [15:0] i_host_wdata;
    logic        o_host_rvalid;
    logic [15:0] o_host_rdata;
    logic        i_clr_start;
    logic [15:0] i_clr_word;
    logic        o_clr_busy;

    mda_vram_arbiter dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_disp_req    (i_disp_req),
        .i_disp_addr   (i_disp_addr),
        .o_disp_valid  (o_disp_valid),
        .o_disp_data   (o_disp_data),
        .i_host_valid  (i_host_valid),
        .o_host_ready  (o_host_ready),
        .i_host_we     (i_host_we),
        .i_host_addr   (i_host_addr),
        .i_host_wdata  (i_host_wdata),
        .o_host_rvalid (o_host_rvalid),
        .o_host_rdata  (o_host_rdata),
        .i_clr_start   (i_clr_start),
        .i_clr_word    (i_clr_word),
        .o_clr_busy    (o_clr_busy)
    );

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic        we;
        logic [10:0] addr;
        logic [15:0] wdata;
        logic [15:0] rexp;
    } vec_t;

    exp_t        dq[$];
    exp_t        hq[$];
    vec_t        vecs[15];
    logic [15:0] model [0:2047];
    int          cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (o_disp_valid) begin
            if (dq.size() == 0) chk("disp_unexpected_valid", 1, 0);
            else begin
                e = dq.pop_front();
                chk("disp_data", o_disp_data, e.data);
                chk("disp_latency", cyc, e.due);
            end
        end
        if (o_host_rvalid) begin
            if (hq.size() == 0) chk("host_unexpected_rvalid", 1, 0);
            else begin
                e = hq.pop_front();
                chk("host_rdata", o_host_rdata, e.data);
                chk("host_latency", cyc, e.due);
            end
        end
    end

    task automatic do_reset(input int n);
        i_reset = 1'b1; i_host_valid = 1'b1; i_host_we = 1'b0;
        i_disp_req = 1'b0; i_clr_start = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("rst_host_ready", o_host_ready, 0);
            @(posedge clk); #1;
            chk("rst_outputs", {o_disp_valid, o_disp_data, o_host_rvalid, o_host_rdata, o_clr_busy}, 0);
        end
        i_reset = 1'b0; i_host_valid = 1'b0;
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic host_op(input logic we, input logic [10:0] a, input logic [15:0] d,
                           input logic [15:0] rexp, output int acc);
        int n = 0;
        exp_t e;
        acc = -1;
        i_host_valid = 1'b1; i_host_we = we; i_host_addr = a; i_host_wdata = d;
        forever begin
            @(negedge clk);
            if (o_host_ready) break;
            n++;
            if (n > 50) begin
                chk("host_accept_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
        if (n <= 50) begin
            acc = cyc;
            if (we) begin
                if (a < 11'd2000) model[a] = d;
            end else begin
                e.data = rexp; e.due = cyc + 2;
                hq.push_back(e);
            end
        end
        @(posedge clk); #1;
        i_host_valid = 1'b0;
    endtask

    task automatic disp_one(input logic [10:0] a, input logic [15:0] exp);
        exp_t e;
        i_disp_req = 1'b1; i_disp_addr = a;
        e.data = exp; e.due = cyc + 2;
        dq.push_back(e);
        @(posedge clk); #1;
        i_disp_req = 1'b0;
    endtask

    task automatic readback_all(input string nm);
        int acc;
        for (int a = 0; a < 2000; a++) host_op(1'b0, 11'(a), 16'h0, model[a], acc);
        repeat (4) @(posedge clk);
        #1;
        chk(nm, hq.size(), 0);
    endtask

    initial begin
        int acc, t0, busy_cycles, ndisp, k, n;
        exp_t e;

        i_reset = 1'b1; i_disp_req = 1'b0; i_disp_addr = '0;
        i_host_valid = 1'b0; i_host_we = 1'b0; i_host_addr = '0; i_host_wdata = '0;
        i_clr_start = 1'b0; i_clr_word = '0;
        for (int a = 0; a < 2048; a++) model[a] = 16'h0;

        vecs[0]  = '{1'b1, 11'd5,    16'h0741, 16'h0000};
        vecs[1]  = '{1'b0, 11'd5,    16'h0000, 16'h0741};
        vecs[2]  = '{1'b1, 11'd0,    16'h0A55, 16'h0000};
        vecs[3]  = '{1'b1, 11'd1,    16'h1B66, 16'h0000};
        vecs[4]  = '{1'b1, 11'd2,    16'h2C77, 16'h0000};
        vecs[5]  = '{1'b1, 11'd3,    16'h3D88, 16'h0000};
        vecs[6]  = '{1'b1, 11'd2000, 16'h1234, 16'h0000};
        vecs[7]  = '{1'b0, 11'd2047, 16'h0000, 16'h0000};
        vecs[8]  = '{1'b0, 11'd0,    16'h0000, 16'h0A55};
        vecs[9]  = '{1'b0, 11'd2000, 16'h0000, 16'h0000};
        vecs[10] = '{1'b1, 11'd1999, 16'hBEEF, 16'h0000};
        vecs[11] = '{1'b0, 11'd1999, 16'h0000, 16'hBEEF};
        vecs[12] = '{1'b1, 11'd7,    16'h1111, 16'h0000};
        vecs[13] = '{1'b1, 11'd7,    16'h2222, 16'h0000};
        vecs[14] = '{1'b0, 11'd7,    16'h0000, 16'h2222};

        do_reset(3);

        // Host writes/reads including out-of-range and back-to-back same address
        for (int v = 0; v < 15; v++) begin
            t0 = cyc;
            host_op(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].rexp, acc);
            chk("vec_accept_cycle", acc, t0);
        end
        repeat (4) @(posedge clk);
        #1;

        // Four back-to-back display fetches hold off a waiting host read
        t0 = cyc;
        fork
            begin
                for (int j = 0; j < 4; j++) begin
                    i_disp_req = 1'b1; i_disp_addr = 11'(j);
                    e.data = model[j]; e.due = cyc + 2;
                    dq.push_back(e);
                    @(negedge clk);
                    chk("t2_host_ready_low", o_host_ready, 0);
                    @(posedge clk); #1;
                end
                i_disp_req = 1'b0;
            end
            host_op(1'b0, 11'd5, 16'h0, 16'h0741, acc);
        join
        chk("t2_host_accept_cycle", acc, t0 + 4);
        repeat (4) @(posedge clk);
        #1;

        // Display and host in the same cycle
        t0 = cyc;
        fork
            disp_one(11'd2, model[2]);
            host_op(1'b0, 11'd1, 16'h0, model[1], acc);
        join
        chk("t6_host_accept_cycle", acc, t0 + 1);
        repeat (4) @(posedge clk);
        #1;

        // Full clear with a display fetch every 9th cycle
        i_clr_start = 1'b1; i_clr_word = 16'h0720;
        @(posedge clk); #1;
        i_clr_start = 1'b0; i_clr_word = 16'hFFFF;
        @(negedge clk);
        chk("t3_busy_rise", o_clr_busy, 1);
        chk("t3_host_ready_busy", o_host_ready, 0);
        busy_cycles = 0; ndisp = 0; k = 0;
        while (o_clr_busy) begin
            busy_cycles++;
            if (i_disp_req) ndisp++;
            if (busy_cycles > 6000) begin
                chk("t3_busy_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
            i_disp_req = 1'b0;
            k++;
            if (k % 9 == 0) begin
                i_disp_req = 1'b1;
                if ((k / 9) % 2 == 1 && busy_cycles < 1500) begin
                    i_disp_addr = 11'd1999; e.data = 16'hBEEF;
                end else begin
                    i_disp_addr = 11'd0; e.data = 16'h0720;
                end
                e.due = cyc + 2;
                dq.push_back(e);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        i_disp_req = 1'b0;
        chk("t3_busy_length", busy_cycles, 2000 + ndisp);
        for (int a = 0; a < 2000; a++) model[a] = 16'h0720;
        readback_all("t3_readback_drained");

        // Out-of-range write must not alias onto address 0
        host_op(1'b1, 11'd2000, 16'h5A5A, 16'h0, acc);
        host_op(1'b0, 11'd0, 16'h0, 16'h0720, acc);
        host_op(1'b0, 11'd2000, 16'h0, 16'h0000, acc);

        // Restart attempt mid-clear is ignored; reset aborts after 1000 words
        i_clr_start = 1'b1; i_clr_word = 16'h0000;
        @(posedge clk); #1;
        i_clr_start = 1'b0; i_clr_word = 16'hFFFF;
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            if (!o_clr_busy) begin
                chk("t5_busy_during_clear", o_clr_busy, 1);
                break;
            end
            n++;
            @(posedge clk); #1;
            if (n == 500) begin
                i_clr_start = 1'b1; i_clr_word = 16'h1111;
            end else begin
                i_clr_start = 1'b0; i_clr_word = 16'hFFFF;
            end
        end
        do_reset(2);
        @(negedge clk);
        chk("t5_busy_after_reset", o_clr_busy, 0);
        @(posedge clk); #1;
        for (int a = 0; a < 1000; a++) model[a] = 16'h0000;
        readback_all("t5_readback_drained");

        repeat (4) @(posedge clk);
        #1;
        chk("final_disp_queue_empty", dq.size(), 0);
        chk("final_host_queue_empty", hq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
